// File: rtl/lynx_video_pkg.sv
// lynx_video_pkg: shared constants and types for the Lynx video fetch path.
// Holds FSM state encodings, default geometry and the bits-per-byte constant.
package lynx_video_pkg;

  localparam int ROWBITS_DEF = 8;
  localparam int COLBITS_DEF = 5;
  localparam int BPB         = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_READY = 2'd3
  } vf_state_e;

  typedef struct packed {
    logic [BPB-1:0] red;
    logic [BPB-1:0] green;
    logic [BPB-1:0] blue;
  } plane_t;

  localparam plane_t PLANE_ZERO = '{red: 8'h00, green: 8'h00, blue: 8'h00};

  // Shift a byte one place toward the MSB, filling with zero.
  function automatic logic [BPB-1:0] shl1(input logic [BPB-1:0] v);
    return {v[BPB-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/lynx_vshift.sv
// lynx_vshift: three 8-bit load/shift registers (red, green, blue planes).
// The serial bit is the MSB of the byte being loaded on a load clock, so
// the first pixel of a group leaves on the same pe that loads it.
module lynx_vshift
  import lynx_video_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  plane_t     din,
  output logic [2:0] pix
);

  plane_t sr_r;

  // Select the outgoing serial bits {red, green, blue}.
  always_comb begin
    if (load) begin
      pix = {din.red[BPB-1], din.green[BPB-1], din.blue[BPB-1]};
    end else begin
      pix = {sr_r.red[BPB-1], sr_r.green[BPB-1], sr_r.blue[BPB-1]};
    end
  end

  // Shift registers: load drops the already-emitted MSB, shift moves left.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr_r <= PLANE_ZERO;
    end else if (load) begin
      sr_r.red   <= shl1(din.red);
      sr_r.green <= shl1(din.green);
      sr_r.blue  <= shl1(din.blue);
    end else if (shift) begin
      sr_r.red   <= shl1(sr_r.red);
      sr_r.green <= shl1(sr_r.green);
      sr_r.blue  <= shl1(sr_r.blue);
    end else begin
      sr_r <= sr_r;
    end
  end

endmodule

// File: rtl/lynx_vfetch.sv
// lynx_vfetch: video RAM fetch sequencer and serial pixel generator.
// Fetches one byte per plane per 8-pixel group, one line at a time.
// Optional feature macro LYNX_ALTGREEN_EN adds an alternate green plane
// (dga) selected by altg, sampled while latching the RAM data.
module lynx_vfetch
  import lynx_video_pkg::*;
#(
  parameter int ROWBITS = ROWBITS_DEF,
  parameter int COLBITS = COLBITS_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pe,
  input  logic                       hs,
  input  logic                       vs,
  input  logic                       de,
  output logic                       ce,
  output logic                       we,
  output logic [ROWBITS+COLBITS-1:0] a,
  input  logic [7:0]                 dr,
  input  logic [7:0]                 db,
  input  logic [7:0]                 dg,
`ifdef LYNX_ALTGREEN_EN
  input  logic [7:0]                 dga,
  input  logic                       altg,
`endif
  output logic                       r,
  output logic                       g,
  output logic                       b,
  output logic                       underrun
);

  vf_state_e                  state_r, state_nxt_s;
  logic [ROWBITS-1:0]         row_r, row_nxt_s;
  logic [COLBITS:0]           col_r, col_nxt_s;
  logic [2:0]                 bitcnt_r;
  plane_t                     hold_r, load_data_s;
  logic                       hold_valid_r;
  logic                       de_d_r;
  logic                       ce_r, we_r, underrun_r;
  logic [ROWBITS+COLBITS-1:0] a_r;
  logic [2:0]                 pix_r, pix_s;
  logic [7:0]                 green_src_s;
  logic                       load_s, shift_s, exhausted_s, de_fall_s;
  logic                       fetch_nxt_s, capture_s;

  assign ce       = ce_r;
  assign we       = we_r;
  assign a        = a_r;
  assign r        = pix_r[2];
  assign g        = pix_r[1];
  assign b        = pix_r[0];
  assign underrun = underrun_r;

  // Pixel pipeline strobes and line bookkeeping conditions.
  always_comb begin
    load_s      = pe & de & (bitcnt_r == 3'd0);
    shift_s     = pe & de & (bitcnt_r != 3'd0);
    exhausted_s = col_r[COLBITS];
    de_fall_s   = de_d_r & ~de;
  end

  // Next row/column; vs beats a coincident de fall, hs restarts the line.
  always_comb begin
    if (vs) begin
      row_nxt_s = {ROWBITS{1'b0}};
    end else if (de_fall_s) begin
      row_nxt_s = row_r + {{(ROWBITS-1){1'b0}}, 1'b1};
    end else begin
      row_nxt_s = row_r;
    end
    if (hs) begin
      col_nxt_s = {(COLBITS+1){1'b0}};
    end else if (state_r == ST_LATCH) begin
      col_nxt_s = col_r + {{COLBITS{1'b0}}, 1'b1};
    end else begin
      col_nxt_s = col_r;
    end
  end

  // Green plane source, optionally the alternate plane.
  always_comb begin
`ifdef LYNX_ALTGREEN_EN
    if (altg) begin
      green_src_s = dga;
    end else begin
      green_src_s = dg;
    end
`else
    green_src_s = dg;
`endif
  end

  // Data handed to the shifters: held bytes, or blank when nothing is held.
  always_comb begin
    if (hold_valid_r) begin
      load_data_s = hold_r;
    end else begin
      load_data_s = PLANE_ZERO;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; hs aborts anything in flight and starts a new line.
  always_comb begin
    state_nxt_s = state_r;
    if (hs) begin
      state_nxt_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_IDLE;
        ST_FETCH: state_nxt_s = ST_LATCH;
        ST_LATCH: state_nxt_s = ST_READY;
        ST_READY: begin
          if (load_s && hold_valid_r) begin
            if (exhausted_s) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_FETCH;
            end
          end else begin
            state_nxt_s = ST_READY;
          end
        end
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: fetch strobe for the coming clock, capture at LATCH close.
  always_comb begin
    fetch_nxt_s = (state_nxt_s == ST_FETCH);
    capture_s   = (state_r == ST_LATCH) && !hs;
  end

  // RAM interface registers; address holds between fetches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ce_r <= 1'b0;
      we_r <= 1'b1;
      a_r  <= {(ROWBITS+COLBITS){1'b0}};
    end else begin
      ce_r <= fetch_nxt_s;
      we_r <= 1'b1;
      if (fetch_nxt_s) begin
        a_r <= {row_nxt_s, col_nxt_s[COLBITS-1:0]};
      end else begin
        a_r <= a_r;
      end
    end
  end

  // Row, column and de history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_r  <= {ROWBITS{1'b0}};
      col_r  <= {(COLBITS+1){1'b0}};
      de_d_r <= 1'b0;
    end else begin
      row_r  <= row_nxt_s;
      col_r  <= col_nxt_s;
      de_d_r <= de;
    end
  end

  // Hold registers capture RAM data; valid until the shifters take it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_r       <= PLANE_ZERO;
      hold_valid_r <= 1'b0;
    end else if (hs) begin
      hold_r       <= hold_r;
      hold_valid_r <= 1'b0;
    end else if (capture_s) begin
      hold_r.red   <= dr;
      hold_r.green <= green_src_s;
      hold_r.blue  <= db;
      hold_valid_r <= 1'b1;
    end else if (load_s) begin
      hold_r       <= hold_r;
      hold_valid_r <= 1'b0;
    end else begin
      hold_r       <= hold_r;
      hold_valid_r <= hold_valid_r;
    end
  end

  // Sticky underrun: a group was due before its data arrived.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underrun_r <= 1'b0;
    end else if (vs) begin
      underrun_r <= 1'b0;
    end else if (load_s && !hold_valid_r && !exhausted_s) begin
      underrun_r <= 1'b1;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  // Bit counter within the 8-pixel group; parked at 0 outside display.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitcnt_r <= 3'd0;
    end else if (!de) begin
      bitcnt_r <= 3'd0;
    end else if (pe) begin
      bitcnt_r <= bitcnt_r + 3'd1;
    end else begin
      bitcnt_r <= bitcnt_r;
    end
  end

  // Serial colour outputs, blank outside display.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_r <= 3'b000;
    end else if (!de) begin
      pix_r <= 3'b000;
    end else if (pe) begin
      pix_r <= pix_s;
    end else begin
      pix_r <= pix_r;
    end
  end

  lynx_vshift u_shift (
    .clock (clock),
    .reset (reset),
    .load  (load_s),
    .shift (shift_s),
    .din   (load_data_s),
    .pix   (pix_s)
  );

endmodule

// File: tb/tb_lynx_vfetch.sv
// tb_lynx_vfetch: randomized self-checking bench for lynx_vfetch.
// A RAM model answers fetches; expected pixels, fetch addresses, fetch counts
// and the underrun flag are derived from line-level rules (data for the first
// group is ready 3 clocks after hs; groups follow columns 0..31, then blank).
module tb_lynx_vfetch;

  localparam int RB = 8;
  localparam int CB = 5;
  localparam int NCOL = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic pe = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic ce, we, r, g, b, underrun;
  logic [RB+CB-1:0] a;
  logic [7:0] dr = 8'h00, db = 8'h00, dg = 8'h00;
`ifdef LYNX_ALTGREEN_EN
  logic [7:0] dga = 8'h00;
  logic       altg = 1'b0;
  logic [7:0] mem_ga [0:8191];
`endif

  logic [7:0] mem_r [0:8191];
  logic [7:0] mem_g [0:8191];
  logic [7:0] mem_b [0:8191];

  int n_checks = 0;
  int n_fail = 0;
  int m_row = 0;
  bit m_under = 1'b0;
  int ce_cnt = 0;
  logic [RB+CB-1:0] ce_addr_q[$];
  logic [2:0] obs_q[$];
  int first_addr = -1;

  always #5 clock = ~clock;

  lynx_vfetch #(.ROWBITS(RB), .COLBITS(CB)) dut (
    .clock(clock), .reset(reset), .pe(pe), .hs(hs), .vs(vs), .de(de),
    .ce(ce), .we(we), .a(a), .dr(dr), .db(db), .dg(dg),
`ifdef LYNX_ALTGREEN_EN
    .dga(dga), .altg(altg),
`endif
    .r(r), .g(g), .b(b), .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: data appears one clock after ce; also logs each fetch.
  always @(negedge clock) begin
    if (reset && ce === 1'b1) begin
      dr = mem_r[a];
      dg = mem_g[a];
      db = mem_b[a];
`ifdef LYNX_ALTGREEN_EN
      dga = mem_ga[a];
`endif
      ce_cnt++;
      ce_addr_q.push_back(a);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    pe = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [2:0] exp_pix(input int row, input int i, input int shift);
    int col, idx, bt;
    logic [7:0] gbyte;
    col = i / 8 - shift;
    if (col < 0 || col >= NCOL) return 3'b000;
    idx = row * NCOL + col;
    bt = 7 - (i % 8);
    gbyte = mem_g[idx];
`ifdef LYNX_ALTGREEN_EN
    if (altg) gbyte = mem_ga[idx];
`endif
    return {mem_r[idx][bt], gbyte[bt], mem_b[idx][bt]};
  endfunction

  // One display line: hs, gap clocks, npix pixels every pgap clocks, de low.
  task automatic run_line(input int gap, input int npix, input int pgap, input bit with_vs);
    int shift, grp, v, fexp, row_l;
    logic [2:0] p;
    if (with_vs) begin
      m_row = 0;
      m_under = 1'b0;
    end
    row_l = m_row;
    ce_cnt = 0;
    ce_addr_q.delete();
    obs_q.delete();
    hs = 1'b1; vs = with_vs; de = 1'b0; pe = 1'b0;
    step();
    hs = 1'b0; vs = 1'b0;
    for (int i = 1; i < gap; i++) step();
    shift = (gap < 3) ? 1 : 0;
    for (int i = 0; i < npix; i++) begin
      pe = 1'b1; de = 1'b1;
      step();
      pe = 1'b0;
      p = {r, g, b};
      obs_q.push_back(p);
      chk("pixel", {29'd0, p}, {29'd0, exp_pix(row_l, i, shift)});
      for (int j = 1; j < pgap; j++) step();
    end
    de = 1'b0;
    step();
    chk("blank_rgb", {29'd0, r, g, b}, 32'd0);
    m_row = (m_row + 1) % 256;
    if (shift == 1) m_under = 1'b1;
    idle(5);
    chk("underrun", {31'd0, underrun}, {31'd0, m_under});
    grp = (npix + 7) / 8;
    v = grp - shift;
    if (v < 0) v = 0;
    if (v > NCOL) v = NCOL;
    fexp = 1 + ((v < NCOL - 1) ? v : NCOL - 1);
    chk("ce_count", ce_cnt, fexp);
    foreach (ce_addr_q[k]) chk("ce_addr", {19'd0, ce_addr_q[k]}, row_l * NCOL + k);
    first_addr = (ce_addr_q.size() > 0) ? int'(ce_addr_q[0]) : -1;
  endtask

  function automatic logic [7:0] obs_byte(input int plane);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) v[7-i] = obs_q[i][plane];
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem_r[i] = 8'($urandom);
      mem_g[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
`ifdef LYNX_ALTGREEN_EN
      mem_ga[i] = 8'($urandom);
`endif
    end
    mem_r[0] = 8'hA5; mem_b[0] = 8'h00; mem_g[0] = 8'hFF;

    // Reset state.
    step(); step();
    chk("rst_ce", {31'd0, ce}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd1);
    chk("rst_a", {19'd0, a}, 32'd0);
    chk("rst_rgb", {29'd0, r, g, b}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b1;

    // No fetch before the first hs, even with pixel enables running.
    ce_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      pe = (i % 3 == 0);
      step();
    end
    pe = 1'b0;
    chk("no_fetch_before_hs", ce_cnt, 0);

    // Three lines advance the row; the fourth fetches row 3.
    for (int i = 0; i < 3; i++) run_line(4, 24, 3, 1'b0);
    run_line(4, 16, 4, 1'b0);
    chk("row3_first_addr", first_addr, 3 * NCOL);

    // hs with vs fetches row 0; known pattern in column 0.
    run_line(4, 8, 3, 1'b1);
    chk("vs_first_addr", first_addr, 0);
    chk("pat_r", obs_byte(2), 8'hA5);
    chk("pat_g", obs_byte(1), 8'hFF);
    chk("pat_b", obs_byte(0), 8'h00);

    // Full line plus overrun pixels.
    run_line(5, 272, 3, 1'b0);
    chk("full_ce_count", ce_cnt, 32);
    chk("full_underrun", {31'd0, underrun}, 32'd0);

    // Late data: underrun, then cleared by vs.
    run_line(1, 16, 3, 1'b0);
    chk("late_underrun", {31'd0, underrun}, 32'd1);
    run_line(4, 8, 3, 1'b1);
    chk("vs_clears_underrun", {31'd0, underrun}, 32'd0);

    // Reset while in LATCH.
    run_line(2, 16, 3, 1'b0);
    hs = 1'b1; step(); hs = 1'b0; step();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ce", {31'd0, ce}, 32'd0);
    chk("mid_rst_we", {31'd0, we}, 32'd1);
    chk("mid_rst_a", {19'd0, a}, 32'd0);
    chk("mid_rst_rgb", {29'd0, r, g, b}, 32'd0);
    chk("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    #2 reset = 1'b1;
    m_row = 0; m_under = 1'b0;
    ce_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      pe = (i % 3 == 0);
      step();
    end
    pe = 1'b0;
    chk("no_fetch_after_rst", ce_cnt, 0);

`ifdef LYNX_ALTGREEN_EN
    // Alternate green plane selection.
    mem_g[m_row * NCOL] = 8'h00; mem_ga[m_row * NCOL] = 8'hFF;
    altg = 1'b1;
    run_line(4, 8, 3, 1'b0);
    chk("altg1_g", obs_byte(1), 8'hFF);
    mem_g[m_row * NCOL] = 8'h00; mem_ga[m_row * NCOL] = 8'hFF;
    altg = 1'b0;
    run_line(4, 8, 3, 1'b0);
    chk("altg0_g", obs_byte(1), 8'h00);
`endif

    // Randomized lines.
    for (int n = 0; n < 25; n++) begin
`ifdef LYNX_ALTGREEN_EN
      altg = 1'($urandom_range(0, 1));
`endif
      run_line($urandom_range(1, 8), $urandom_range(1, 272),
               $urandom_range(3, 5), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
